// File: rtl/truth_table_lut_seq.sv
// Run-time programmable N-input gate: serially loaded truth table, output
// updates only after the input vector has been stable for SETTLE cycles.
module truth_table_lut_seq #(
    parameter int unsigned        N_IN     = 3,
    parameter int unsigned        SETTLE   = 4,
    parameter logic [(2**N_IN)-1:0] TT_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    input  logic            cfg_last,
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic            cfg_err,
    input  logic [N_IN-1:0] in_vec,
    output logic            out,
    output logic            out_valid,
    output logic            out_chg
);

    localparam int unsigned TT_W    = 2 ** N_IN;
    localparam int unsigned BC_W    = $clog2(TT_W + 1);
    localparam int unsigned CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned CNT_MAX = SETTLE - 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TT_W-1:0]   tt_q, tt_d;
    logic [TT_W-1:0]   sh_q, sh_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N_IN-1:0]   in_q;
    logic [CNT_W-1:0]  stable_cnt_q, stable_cnt_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              out_chg_q, out_chg_d;
    logic              cfg_done_q, cfg_done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_ready_q;

    // Load-port decode shared by the next-state and output processes
    logic              accept;
    logic              is_full;
    logic              commit;
    logic              abort;
    logic [BC_W-1:0]   bit_cnt_inc;
    logic [TT_W-1:0]   sh_shifted;
    logic              in_same;
    logic              settle_hit;

    assign accept      = cfg_valid & cfg_ready_q;
    assign bit_cnt_inc = bit_cnt_q + BC_W'(1);
    assign is_full     = (bit_cnt_inc == BC_W'(TT_W));
    assign commit      = accept & cfg_last & is_full;
    assign abort       = accept & (cfg_last ^ is_full);
    assign sh_shifted  = {sh_q[TT_W-2:0], cfg_bit};
    assign in_same     = (in_vec == in_q);
    assign settle_hit  = (state_q == ST_RUN) && in_same
                         && (stable_cnt_q == CNT_W'(CNT_MAX));

    // State register and all datapath/output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            tt_q         <= TT_RESET;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            in_q         <= '0;
            stable_cnt_q <= '0;
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_chg_q    <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tt_q         <= tt_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            in_q         <= in_vec;
            stable_cnt_q <= stable_cnt_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            out_chg_q    <= out_chg_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            cfg_ready_q  <= 1'b1;
        end
    end

    // Next state: a load ends on commit or abort, otherwise any accepted bit means LOAD
    always_comb begin
        state_d = state_q;
        if (commit || abort) begin
            state_d = ST_RUN;
        end else if (accept) begin
            state_d = ST_LOAD;
        end
    end

    // Next values of table, shift register, settle tracking and outputs
    always_comb begin
        tt_d         = tt_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        stable_cnt_d = '0;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        out_chg_d    = 1'b0;
        cfg_done_d   = 1'b0;
        cfg_err_d    = 1'b0;

        if (accept) begin
            sh_d      = sh_shifted;
            bit_cnt_d = bit_cnt_inc;
        end
        if (commit) begin
            tt_d       = sh_shifted;
            bit_cnt_d  = '0;
            cfg_done_d = 1'b1;
        end
        if (abort) begin
            bit_cnt_d = '0;
            cfg_err_d = 1'b1;
        end

        if (in_same) begin
            stable_cnt_d = (stable_cnt_q == CNT_W'(CNT_MAX)) ? stable_cnt_q
                                                              : stable_cnt_q + CNT_W'(1);
        end else begin
            out_valid_d = 1'b0;
        end
        // A fresh table restarts the full settle window
        if (commit) begin
            stable_cnt_d = '0;
        end

        if (settle_hit) begin
            out_d       = tt_q[in_q];
            out_valid_d = 1'b1;
            out_chg_d   = (tt_q[in_q] != out_q);
        end
        if (state_d == ST_LOAD) begin
            out_valid_d = 1'b0;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_chg   = out_chg_q;

endmodule

// File: tb/tb_truth_table_lut_seq.sv
// Self-checking bench for truth_table_lut_seq: directed scenarios plus a random
// run, all checked against a run-length/queue based reference model.
module tb_truth_table_lut_seq;

    localparam int          N_IN    = 3;
    localparam int          SETTLE  = 4;
    localparam int          TT_W    = 8;
    localparam logic [7:0]  TT_INIT = 8'hB7;
    localparam logic [7:0]  TT_A    = 8'h96;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_bit;
    logic       cfg_last;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic [2:0] in_vec;
    logic       out;
    logic       out_valid;
    logic       out_chg;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0] m_tt;
    bit         m_bits[$];
    bit         m_loading;
    logic [2:0] m_last;
    int         m_run;
    logic       m_out, m_valid, m_chg, m_done, m_err, m_ready;

    truth_table_lut_seq #(
        .N_IN    (N_IN),
        .SETTLE  (SETTLE),
        .TT_RESET(TT_INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_bit  (cfg_bit),
        .cfg_last (cfg_last),
        .cfg_ready(cfg_ready),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
        .in_vec   (in_vec),
        .out      (out),
        .out_valid(out_valid),
        .out_chg  (out_chg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    // m_run = number of consecutive edges that have sampled the current in_vec
    function automatic void model_step();
        logic [2:0] prev;
        logic [7:0] tt_before;
        bit         was_loading;
        bit         same;
        bit         commit;
        if (rst) begin
            m_tt = TT_INIT; m_bits.delete(); m_loading = 0;
            m_last = '0; m_run = 1;
            m_out = 0; m_valid = 0; m_chg = 0; m_done = 0; m_err = 0; m_ready = 0;
            return;
        end
        prev        = m_last;
        tt_before   = m_tt;
        was_loading = m_loading;
        commit      = 0;
        m_done = 0; m_err = 0; m_chg = 0;
        if (cfg_valid && m_ready) begin
            m_bits.push_back(cfg_bit);
            if (cfg_last && m_bits.size() == TT_W) begin
                for (int i = 0; i < TT_W; i++) m_tt[TT_W-1-i] = m_bits[i];
                m_done = 1; commit = 1; m_bits.delete(); m_loading = 0;
            end else if (cfg_last || m_bits.size() == TT_W) begin
                m_err = 1; m_bits.delete(); m_loading = 0;
            end else begin
                m_loading = 1;
            end
        end
        same   = (in_vec == prev);
        m_run  = same ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
        m_last = in_vec;
        if (!same) m_valid = 0;
        if (!was_loading && same && m_run >= SETTLE + 1) begin
            m_chg   = (tt_before[prev] != m_out);
            m_out   = tt_before[prev];
            m_valid = 1;
        end
        if (commit) m_run = 1;
        if (m_loading) m_valid = 0;
        m_ready = 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got, exp;
        rst = 1; cfg_valid = 0; cfg_bit = 0; cfg_last = 0; in_vec = 3'b001;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({out, out_valid, cfg_ready, cfg_done, cfg_err, out_chg} !== 6'b0) begin
                n_fails++;
                $display("FAIL reset_hold: got %b required 000000",
                         {out, out_valid, cfg_ready, cfg_done, cfg_err, out_chg});
            end
        end
        rst = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL reset_release edge %0d: got %b required %b", i, got, exp);
            end
            n_checks++;
            if (out_valid !== (i == 5)) begin
                n_fails++;
                $display("FAIL reset_latency edge %0d: out_valid=%b required %b", i, out_valid, i == 5);
            end
        end
        n_checks++;
        if (out !== TT_INIT[1]) begin
            n_fails++;
            $display("FAIL reset_out: out=%b required %b", out, TT_INIT[1]);
        end
    endtask

    task automatic test_step();
        logic [5:0] got, exp;
        in_vec = 3'b011;
        for (int i = 1; i <= 6; i++) begin
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL step edge %0d: got %b required %b", i, got, exp);
            end
            if (i == 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fails++;
                    $display("FAIL step_invalid: out_valid=%b required 0", out_valid);
                end
            end
            if (i == 5) begin
                n_checks++;
                if (out !== TT_INIT[3] || out_chg !== (TT_INIT[3] != TT_INIT[1])) begin
                    n_fails++;
                    $display("FAIL step_update: out=%b chg=%b required out=%b chg=%b",
                             out, out_chg, TT_INIT[3], TT_INIT[3] != TT_INIT[1]);
                end
            end
            if (i == 6) begin
                n_checks++;
                if (out_chg !== 1'b0) begin
                    n_fails++;
                    $display("FAIL step_pulse_width: out_chg=%b required 0", out_chg);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [5:0] got, exp;
        for (int i = 1; i <= 8; i++) begin
            in_vec = (i <= 3) ? 3'b100 : 3'b011;
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL glitch edge %0d: got %b required %b", i, got, exp);
            end
            n_checks++;
            if (out !== TT_INIT[3] || out_chg !== 1'b0) begin
                n_fails++;
                $display("FAIL glitch_leak edge %0d: out=%b chg=%b required out=%b chg=0",
                         i, out, out_chg, TT_INIT[3]);
            end
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL glitch_recover: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic test_load_commit();
        logic [5:0] got, exp;
        in_vec = 3'b000;
        for (int i = 0; i < 6; i++) tick();
        for (int i = TT_W - 1; i >= -4; i--) begin
            cfg_valid = (i >= 0);
            cfg_bit   = (i >= 0) ? TT_A[i] : 1'b0;
            cfg_last  = (i == 0);
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL load edge %0d: got %b required %b", i, got, exp);
            end
            n_checks++;
            if (cfg_done !== (i == 0)) begin
                n_fails++;
                $display("FAIL load_done edge %0d: cfg_done=%b required %b", i, cfg_done, i == 0);
            end
            n_checks++;
            if (i > -4 && out !== TT_INIT[0]) begin
                n_fails++;
                $display("FAIL load_hold edge %0d: out=%b required %b", i, out, TT_INIT[0]);
            end else if (i == -4 && (out !== TT_A[0] || out_chg !== 1'b1)) begin
                n_fails++;
                $display("FAIL load_newtable: out=%b chg=%b required out=%b chg=1",
                         out, out_chg, TT_A[0]);
            end
        end
        cfg_valid = 0; cfg_last = 0;
    endtask

    task automatic test_abort();
        logic [5:0] got, exp;
        for (int pass = 0; pass < 2; pass++) begin
            int nbits;
            nbits = (pass == 0) ? 5 : 8;
            for (int i = 1; i <= nbits + 1; i++) begin
                cfg_valid = (i <= nbits);
                cfg_bit   = 1'($urandom_range(0, 1));
                cfg_last  = (pass == 0) && (i == nbits);
                tick();
                got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
                exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
                n_checks++;
                if (got !== exp) begin
                    n_fails++;
                    $display("FAIL abort%0d edge %0d: got %b required %b", pass, i, got, exp);
                end
                n_checks++;
                if (cfg_err !== (i == nbits) || cfg_done !== 1'b0) begin
                    n_fails++;
                    $display("FAIL abort%0d_err edge %0d: err=%b done=%b required err=%b done=0",
                             pass, i, cfg_err, cfg_done, i == nbits);
                end
            end
        end
        cfg_valid = 0; cfg_last = 0;
        for (int idx = 0; idx < TT_W; idx++) begin
            in_vec = 3'(idx);
            for (int i = 0; i < 5; i++) tick();
            n_checks++;
            if (out !== TT_A[idx] || out_valid !== 1'b1) begin
                n_fails++;
                $display("FAIL abort_keep idx %0d: out=%b valid=%b required out=%b valid=1",
                         idx, out, out_valid, TT_A[idx]);
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] v;
        logic [5:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1; cfg_bit = 1'($urandom_range(0, 1)); cfg_last = 0;
            tick();
        end
        cfg_valid = 0; rst = 1;
        tick(); tick();
        rst = 0; in_vec = 3'b101;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (out !== TT_INIT[5] || out_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL midload_reset: out=%b valid=%b required out=%b valid=1",
                     out, out_valid, TT_INIT[5]);
        end
        v = 8'($urandom_range(0, 255));
        for (int i = TT_W - 1; i >= -1; i--) begin
            cfg_valid = (i >= 0);
            cfg_bit   = (i >= 0) ? v[i] : 1'b0;
            cfg_last  = (i == 0);
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL midload_reload edge %0d: got %b required %b", i, got, exp);
            end
        end
        cfg_valid = 0; cfg_last = 0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = int'($urandom_range(0, 7));
            in_vec = 3'(idx);
            for (int i = 0; i < 6; i++) tick();
            n_checks++;
            if (out !== v[idx]) begin
                n_fails++;
                $display("FAIL midload_newtable idx %0d: out=%b required %b", idx, out, v[idx]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) in_vec = 3'($urandom_range(0, 7));
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_bit   = 1'($urandom_range(0, 1));
            cfg_last  = (m_bits.size() == TT_W - 1) ? ($urandom_range(0, 9) != 0)
                                                    : ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 499) == 0);
            tick();
            got = {out, out_valid, out_chg, cfg_done, cfg_err, cfg_ready};
            exp = {m_out, m_valid, m_chg, m_done, m_err, m_ready};
            n_checks++;
            if (got !== exp) begin
                n_fails++;
                $display("FAIL random cycle %0d: got %b required %b", n, got, exp);
            end
        end
        rst = 0; cfg_valid = 0; cfg_last = 0;
    endtask

    initial begin
        rst = 1; cfg_valid = 0; cfg_bit = 0; cfg_last = 0; in_vec = 3'b001;
        test_reset();
        test_step();
        test_glitch();
        test_load_commit();
        test_abort();
        test_reset_midload();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
